// File: rtl/camera_capture_ctrl_pkg.sv
// camera_capture_ctrl_pkg: shared frame geometry, capture FSM states and RGB565->RGB332 packing
package camera_capture_ctrl_pkg;
  localparam int CAM_WIDTH  = 176;
  localparam int CAM_HEIGHT = 144;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_DONE} cap_state_e;
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction
endpackage

// File: rtl/camera_capture_ctrl_if.sv
// camera_capture_ctrl_if: OV7670 camera bus toward the controller, M9K write port away from it
interface camera_capture_ctrl_if #(parameter int ADDR_W = 15);
  logic              CAM_PCLK;
  logic              CAM_HREF;
  logic              CAM_VSYNC;
  logic [7:0]        CAM_DATA;
  logic [ADDR_W-1:0] W_ADDR;
  logic [7:0]        W_DATA;
  logic              W_EN;
  modport master (input CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_DATA, output W_ADDR, W_DATA, W_EN);
  modport slave  (output CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_DATA, input W_ADDR, W_DATA, W_EN);
endinterface

// File: rtl/camera_capture_ctrl_cam_input_sync.sv
// cam_input_sync: synchronizes the camera bus as one word so DATA stays aligned with PCLK, then detects edges
module cam_input_sync #(parameter int SYNC_STAGES = 2) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pclk,
  input  logic       href,
  input  logic       vsync,
  input  logic [7:0] data,
  output logic       pclk_rise,
  output logic       href_s,
  output logic       href_fall,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic [7:0] data_s
);
  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] sync_d [SYNC_STAGES];
  logic [10:0] tap;
  logic [2:0]  prev_q, prev_d;
  always_comb begin
    sync_d[0] = {pclk, href, vsync, data};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    tap    = sync_q[SYNC_STAGES-1];
    prev_d = tap[10:8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign pclk_rise  = tap[10] & ~prev_q[2];
  assign href_s     = tap[9];
  assign href_fall  = ~tap[9] & prev_q[1];
  assign vsync_rise = tap[8] & ~prev_q[0];
  assign vsync_fall = ~tap[8] & prev_q[0];
  assign data_s     = tap[7:0];
endmodule

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: captures OV7670 RGB565 frames as RGB332 pixels into the frame-buffer write port
module camera_capture_ctrl
  import camera_capture_ctrl_pkg::*;
#(
  parameter int WIDTH       = CAM_WIDTH,
  parameter int HEIGHT      = CAM_HEIGHT,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_NEG,
  input  logic                  START,
  input  logic                  CONTINUOUS,
  camera_capture_ctrl_if.master bus,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  LINE_ERR,
  output logic                  FRAME_ERR,
  output logic [7:0]            FRAME_COUNT
);
  localparam logic [8:0]        W9 = 9'(WIDTH);
  localparam logic [8:0]        H9 = 9'(HEIGHT);
  localparam logic [ADDR_W-1:0] WA = ADDR_W'(WIDTH);
  logic pclk_rise, href_s, href_fall, vsync_rise, vsync_fall;
  logic [7:0] data_s;
  cap_state_e state_q, state_d;
  logic [8:0] x_q, x_d, y_q, y_d, y_inc;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, w_addr_q, w_addr_d;
  logic phase_q, phase_d, w_en_q, w_en_d, busy_q, busy_d, done_q, done_d;
  logic line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic [7:0] byte1_q, byte1_d, w_data_q, w_data_d, fcount_q, fcount_d;
  cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(CLK), .rst_n(RESET_NEG), .pclk(bus.CAM_PCLK), .href(bus.CAM_HREF), .vsync(bus.CAM_VSYNC),
    .data(bus.CAM_DATA), .pclk_rise(pclk_rise), .href_s(href_s), .href_fall(href_fall),
    .vsync_rise(vsync_rise), .vsync_fall(vsync_fall), .data_s(data_s)
  );
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    addr_d = addr_q;
    base_d = base_q;
    phase_d = phase_q;
    byte1_d = byte1_q;
    w_en_d = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    line_err_d = line_err_q;
    frame_err_d = frame_err_q;
    fcount_d = fcount_q;
    y_inc = (y_q == '1) ? y_q : y_q + 9'd1;
    case (state_q)
      ST_IDLE: if (START) begin
        state_d = ST_ARM;
        busy_d = 1'b1;
        line_err_d = 1'b0;
        frame_err_d = 1'b0;
      end
      ST_ARM: if (vsync_fall) begin
        state_d = ST_CAPTURE;
        x_d = '0;
        y_d = '0;
        addr_d = '0;
        base_d = '0;
        phase_d = 1'b0;
      end
      ST_CAPTURE: begin
        if (pclk_rise && href_s) begin
          phase_d = ~phase_q;
          byte1_d = phase_q ? byte1_q : data_s;
          if (phase_q) begin
            x_d = (x_q == '1) ? x_q : x_q + 9'd1;
            if (x_q < W9 && y_q < H9) begin
              w_en_d = 1'b1;
              w_addr_d = addr_q;
              w_data_d = rgb565_to_rgb332(byte1_q, data_s);
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        // line close runs before the frame check so a coincident VSYNC rise sees the new y
        if (href_fall) begin
          line_err_d = line_err_q | (x_q != W9);
          x_d = '0;
          phase_d = 1'b0;
          y_d = y_inc;
          base_d = base_q + WA;
          addr_d = base_q + WA;
        end
        if (vsync_rise) begin
          frame_err_d = frame_err_q | ((href_fall ? y_inc : y_q) != H9);
          state_d = ST_DONE;
          done_d = 1'b1;
          fcount_d = fcount_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = CONTINUOUS ? ST_ARM : ST_IDLE;
        busy_d = CONTINUOUS;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_NEG) begin
    if (!RESET_NEG) begin
      state_q <= ST_IDLE;
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
      base_q <= '0;
      phase_q <= 1'b0;
      byte1_q <= '0;
      w_en_q <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      line_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      fcount_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
      base_q <= base_d;
      phase_q <= phase_d;
      byte1_q <= byte1_d;
      w_en_q <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      line_err_q <= line_err_d;
      frame_err_q <= frame_err_d;
      fcount_q <= fcount_d;
    end
  end
  assign bus.W_EN    = w_en_q;
  assign bus.W_ADDR  = w_addr_q;
  assign bus.W_DATA  = w_data_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;
  assign LINE_ERR    = line_err_q;
  assign FRAME_ERR   = frame_err_q;
  assign FRAME_COUNT = fcount_q;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// tb_camera_capture_ctrl: drives scaled-down camera frames and checks writes and status against a frame-level model
module tb_camera_capture_ctrl;
  localparam int W = 16, H = 12, AW = 15;
  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { int nlines; int ly; int ln; int sy; int sn; bit lerr; bit ferr; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0;
  logic busy, frame_done, line_err, frame_err;
  logic [7:0] frame_count;
  wr_t exp_q[$], act_q[$];
  int lens[64];
  int chk_cnt = 0, pass_cnt = 0, done_cnt = 0, busy_drop = 0, exp_fc = 0;
  bit busy_watch = 1'b0;
  vec_t vecs[5];
  camera_capture_ctrl_if #(.ADDR_W(AW)) bus ();
  camera_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .CLK(clk), .RESET_NEG(rst_n), .START(start), .CONTINUOUS(cont), .bus(bus),
    .BUSY(busy), .FRAME_DONE(frame_done), .LINE_ERR(line_err), .FRAME_ERR(frame_err),
    .FRAME_COUNT(frame_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.W_EN) act_q.push_back({bus.W_ADDR, bus.W_DATA});
    if (frame_done) done_cnt++;
    if (busy_watch && !busy) busy_drop++;
  end
  function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic chk_writes(input string name);
    int bad = -1;
    if (act_q.size() == exp_q.size())
      foreach (exp_q[i]) if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
    chk_cnt++;
    if (act_q.size() == exp_q.size() && bad < 0) pass_cnt++;
    else if (bad >= 0)
      $display("FAIL %s: write %0d got addr %0d data 0x%0h expected addr %0d data 0x%0h",
               name, bad, act_q[bad].a, act_q[bad].d, exp_q[bad].a, exp_q[bad].d);
    else $display("FAIL %s: got %0d writes expected %0d", name, act_q.size(), exp_q.size());
    exp_q.delete();
    act_q.delete();
  endtask
  task automatic set_lens();
    for (int i = 0; i < 64; i++) lens[i] = W;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    bus.CAM_PCLK = 1'b0;
    bus.CAM_DATA = d;
    tick(2);
    bus.CAM_PCLK = 1'b1;
    tick(2);
  endtask
  // Model: a captured pixel (x,y) inside WxH lands at y*W+x; everything else is dropped
  task automatic frame_lines(input int nlines, input bit cap, input int start_line, input int stop_pix);
    logic [7:0] b1, b2;
    int pix = 0;
    bus.CAM_VSYNC = 1'b0;
    tick(6);
    for (int y = 0; y < nlines; y++) begin
      if (y == start_line) pulse_start();
      bus.CAM_HREF = 1'b1;
      for (int x = 0; x < lens[y]; x++) begin
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_byte(b1);
        send_byte(b2);
        if (cap && y < H && x < W) exp_q.push_back({AW'(y * W + x), rgb332(b1, b2)});
        if (pix == stop_pix) return;
        pix++;
      end
      bus.CAM_PCLK = 1'b0;
      bus.CAM_HREF = 1'b0;
      tick(6);
    end
  endtask
  task automatic frame_end();
    bus.CAM_VSYNC = 1'b1;
    tick(12);
  endtask
  task automatic run_single(input string tag, input int nlines);
    int d0;
    logic [AW-1:0] last_a;
    pulse_start();
    tick(1);
    chk({tag, "_busy_armed"}, busy, 1);
    d0 = done_cnt;
    frame_lines(nlines, 1'b1, -1, -1);
    frame_end();
    exp_fc++;
    if (exp_q.size() > 0) begin
      last_a = exp_q[$].a;
      chk({tag, "_last_addr"}, bus.W_ADDR, last_a);
    end
    chk_writes({tag, "_writes"});
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_frame_count"}, frame_count, 8'(exp_fc));
    chk({tag, "_busy_idle"}, busy, 0);
  endtask
  initial begin
    int d0, nl;
    bit le;
    vecs[0] = '{H, -1, 0, -1, 0, 1'b0, 1'b0};
    vecs[1] = '{H, 10, W + 4, 11, W - 6, 1'b1, 1'b0};
    vecs[2] = '{H + 6, -1, 0, -1, 0, 1'b0, 1'b1};
    vecs[3] = '{H - 2, -1, 0, -1, 0, 1'b0, 1'b1};
    vecs[4] = '{H, 0, W - 1, -1, 0, 1'b1, 1'b0};
    bus.CAM_PCLK = 1'b0;
    bus.CAM_HREF = 1'b0;
    bus.CAM_VSYNC = 1'b1;
    bus.CAM_DATA = 8'h00;
    tick(3);
    chk("reset_state", {bus.W_ADDR, bus.W_DATA, bus.W_EN, busy, frame_done, line_err, frame_err, frame_count}, 0);
    rst_n = 1'b1;
    tick(4);
    foreach (vecs[i]) begin
      set_lens();
      if (vecs[i].ly >= 0) lens[vecs[i].ly] = vecs[i].ln;
      if (vecs[i].sy >= 0) lens[vecs[i].sy] = vecs[i].sn;
      run_single($sformatf("vec%0d", i), vecs[i].nlines);
      chk($sformatf("vec%0d_line_err", i), line_err, vecs[i].lerr);
      chk($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].ferr);
    end
    for (int r = 0; r < 3; r++) begin
      nl = $urandom_range(H + 2, H - 2);
      le = 1'b0;
      set_lens();
      for (int y = 0; y < nl; y++) begin
        lens[y] = $urandom_range(W + 2, W - 2);
        if (lens[y] != W) le = 1'b1;
      end
      run_single($sformatf("rnd%0d", r), nl);
      chk($sformatf("rnd%0d_line_err", r), line_err, le);
      chk($sformatf("rnd%0d_frame_err", r), frame_err, nl != H);
    end
    set_lens();
    d0 = done_cnt;
    frame_lines(H, 1'b0, 3, -1);
    frame_end();
    chk_writes("midstart_no_writes");
    chk("midstart_busy", busy, 1);
    chk("midstart_no_done", done_cnt - d0, 0);
    frame_lines(H, 1'b1, -1, -1);
    frame_end();
    exp_fc++;
    chk_writes("midstart_next_frame");
    chk("midstart_frame_count", frame_count, 8'(exp_fc));
    chk("midstart_errs", {line_err, frame_err}, 0);
    cont = 1'b1;
    pulse_start();
    tick(1);
    busy_watch = 1'b1;
    d0 = done_cnt;
    frame_lines(H, 1'b1, -1, -1);
    frame_end();
    frame_lines(H, 1'b1, 5, -1);
    frame_end();
    frame_lines(H, 1'b1, -1, -1);
    cont = 1'b0;
    busy_watch = 1'b0;
    frame_end();
    exp_fc += 3;
    chk_writes("cont_writes");
    chk("cont_done_pulses", done_cnt - d0, 3);
    chk("cont_frame_count", frame_count, 8'(exp_fc));
    chk("cont_busy_drops", busy_drop, 0);
    chk("cont_busy_end", busy, 0);
    pulse_start();
    tick(1);
    frame_lines(H, 1'b1, -1, 100);
    tick(1);
    #2;
    chk("wen_before_reset", bus.W_EN, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_frame", {bus.W_ADDR, bus.W_DATA, bus.W_EN, busy, frame_done, line_err, frame_err, frame_count}, 0);
    chk_writes("reset_partial_writes");
    bus.CAM_PCLK = 1'b0;
    bus.CAM_HREF = 1'b0;
    bus.CAM_VSYNC = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    d0 = done_cnt;
    frame_lines(H, 1'b0, -1, -1);
    frame_end();
    chk_writes("post_reset_no_writes");
    chk("post_reset_busy", busy, 0);
    chk("post_reset_frame_count", frame_count, 0);
    chk("post_reset_no_done", done_cnt - d0, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/camera_capture_ctrl.md
Name: camera_capture_ctrl

Overview:
Sequences the write port of the frame-buffer M9K from the OV7670 camera bus. Samples PCLK/HREF/VSYNC/D[7:0] in the system clock domain and pairs RGB565 bytes into RGB332 pixels. Generates a linear write address, a write data byte and a one-cycle write strobe. Runs single-shot or continuous frame capture with a start/done handshake to the top level, and flags malformed lines and frames.

Parameters:
WIDTH, 176, pixels per line written to the buffer
HEIGHT, 144, lines per frame written to the buffer
ADDR_W, 15, write address width
SYNC_STAGES, 2, synchronizer depth on all camera inputs

Ports:
CLK  input  1  system clock; must be more than 2x camera PCLK
RESET_NEG  input  1  asynchronous active-low reset
CAM_PCLK  input  1  camera pixel clock, sampled as data
CAM_HREF  input  1  line valid, active high
CAM_VSYNC  input  1  frame sync, active high
CAM_DATA  input  8  camera byte bus
START  input  1  one-cycle capture request
CONTINUOUS  input  1  1 = re-arm after every frame
W_ADDR  output  ADDR_W  M9K write address
W_DATA  output  8  RGB332 pixel
W_EN  output  1  one-cycle write strobe
BUSY  output  1  high from START acceptance until frame end
FRAME_DONE  output  1  one-cycle pulse at frame end
LINE_ERR  output  1  sticky: line had pixel count other than WIDTH
FRAME_ERR  output  1  sticky: frame had line count other than HEIGHT
FRAME_COUNT  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; synchronizers cleared.
- Inputs: PCLK, HREF, VSYNC and DATA each pass through SYNC_STAGES flops, keeping DATA aligned with PCLK. A PCLK rise is the sample event: synced PCLK is 1 and was 0 in the previous cycle.
- FSM states:
  - IDLE: START moves to ARM; BUSY goes high on the next cycle. START in any other state is ignored.
  - ARM: waits for a synced VSYNC falling edge, then moves to CAPTURE with x=0, y=0, addr=0 and the byte phase cleared. This discards any partial frame in progress.
  - CAPTURE: on each sample event with HREF=1, phase 0 latches byte1 and phase 1 forms the pixel {byte1[7:5], byte1[2:0], data[4:3]}.
    - If x<WIDTH and y<HEIGHT: W_DATA=pixel, W_ADDR=addr, and W_EN is high for exactly one CLK, one cycle after the sample event. Then addr++ and x++.
    - Beyond bounds: no write; x still counts, saturating at 2^9-1.
  - HREF falling edge in CAPTURE: if x!=WIDTH, set LINE_ERR. A dangling phase-1 byte is dropped. Then x=0, phase=0, y++ (saturating), and addr is recomputed as y*WIDTH via a running add of WIDTH, with no multiplier. Lines with y>=HEIGHT are not written.
  - VSYNC rising edge in CAPTURE: if y!=HEIGHT, set FRAME_ERR. Move to DONE.
  - DONE: for one cycle, FRAME_DONE=1 and FRAME_COUNT++. Then go to ARM if CONTINUOUS=1, otherwise go to IDLE with BUSY=0.
- Simultaneous HREF fall and VSYNC rise: the line closes first, then the frame check uses the incremented y.
- LINE_ERR and FRAME_ERR clear only on START acceptance or reset.
- CONTINUOUS is sampled only in DONE.
- Reset mid-frame: W_EN drops immediately (async) and no partial write is issued.
- W_ADDR and W_DATA hold their last values between strobes.

Decomposition:
- Shared package/header: WIDTH/HEIGHT defaults (shared with the frame-buffer read logic), FSM state encodings (IDLE, ARM, CAPTURE, DONE), and the RGB565->RGB332 bit-slice as a function or macro.
- One sub-module: cam_input_sync. It holds the synchronizer chain plus edge detectors and outputs pclk_rise, href_fall, vsync_rise, vsync_fall and aligned data.

Test Plan:
- START with CONTINUOUS=0 and one clean 176x144 frame (byte1=0xE0, byte2=0x1C for every pixel) -> 25344 W_EN strobes; W_DATA=0xE3 (byte1[7:5]=111, byte1[2:0]=000, byte2[4:3]=11); last W_ADDR=25343; FRAME_DONE pulse; FRAME_COUNT=1; BUSY low; no errors.
- START issued mid-frame -> no writes until the next VSYNC fall; the following frame is fully captured from addr 0.
- Line 10 carries 180 pixels and line 11 carries 170 pixels -> no write beyond x=175 on line 10; line 11 starts at addr 11*176=1936; LINE_ERR=1.
- Frame of 150 lines -> writes stop at addr 25343; FRAME_ERR=1; FRAME_DONE still pulses.
- CONTINUOUS=1 over 3 frames -> 3 FRAME_DONE pulses and FRAME_COUNT=3; BUSY stays high throughout; START during CAPTURE is ignored.
- RESET_NEG asserted at pixel 1000 -> W_EN=0 within the reset cycle and all outputs 0; after release the FSM is in IDLE and no writes occur without START.
